reorder_buffer: RTL

//  In-order retirement buffer that sits directly upstream of the architectural register file's single write port.
//  - Dispatch allocates one entry per cycle in program order.
//  - Execution units complete entries out of order, by tag.
//  - The oldest completed entry retires each cycle and drives the register-file write port (w_en/rd_addr/w_data).

---
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer feeding the register file's single write port.
// Optional commit counter (commit_cnt_o) enabled by defining ROB_COMMIT_CNT_EN.
module reorder_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  input  logic [4:0]       alloc_rd_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             cmpl_valid_i,
  input  logic [TAG_W-1:0] cmpl_tag_i,
  input  logic [WIDTH-1:0] cmpl_data_i,
  output logic             rf_w_en_o,
  output logic [4:0]       rf_rd_addr_o,
  output logic [WIDTH-1:0] rf_w_data_o,
  output logic             empty_o
`ifdef ROB_COMMIT_CNT_EN
  ,
  output logic [31:0]      commit_cnt_o
`endif
);

  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [TAG_W:0]   head_q, head_d;
  logic [TAG_W:0]   tail_q, tail_d;
  logic             rf_w_en_q, rf_w_en_d;
  logic [4:0]       rf_rd_addr_q, rf_rd_addr_d;
  logic [WIDTH-1:0] rf_w_data_q, rf_w_data_d;

  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full, alloc_fire, cmpl_fire, commit_fire;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Same index with differing wrap bits means every slot is occupied.
  assign full        = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign alloc_fire  = alloc_valid_i && !full;
  assign cmpl_fire   = cmpl_valid_i && valid_q[cmpl_tag_i];
  assign commit_fire = valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    valid_d      = valid_q;
    done_d       = done_q;
    head_d       = head_q;
    tail_d       = tail_q;
    rf_w_en_d    = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_w_data_d  = rf_w_data_q;
    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (cmpl_fire) begin
        done_d[cmpl_tag_i] = 1'b1;
      end
      // Commit uses pre-edge done, so a head completed this cycle retires next cycle.
      if (commit_fire) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + PTR_ONE;
        rf_w_en_d         = (rd_q[head_idx] != 5'd0);
        rf_rd_addr_d      = rd_q[head_idx];
        rf_w_data_d       = data_q[head_idx];
      end
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      rf_w_en_q    <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_w_data_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      done_q       <= done_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      rf_w_en_q    <= rf_w_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_w_data_q  <= rf_w_data_d;
    end
  end

  // Entry payload needs no reset: it is only read while the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (!flush_i && cmpl_fire) begin
      data_q[cmpl_tag_i] <= cmpl_data_i;
    end
    if (!flush_i && alloc_fire) begin
      rd_q[tail_idx] <= alloc_rd_i;
    end
  end

`ifdef ROB_COMMIT_CNT_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (!flush_i && commit_fire) begin
      commit_cnt_d = commit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      commit_cnt_q <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign commit_cnt_o = commit_cnt_q;
`endif

  assign alloc_ready_o = !full;
  assign alloc_tag_o   = tail_idx;
  assign empty_o       = (head_q == tail_q);
  assign rf_w_en_o     = rf_w_en_q;
  assign rf_rd_addr_o  = rf_rd_addr_q;
  assign rf_w_data_o   = rf_w_data_q;

endmodule
